// File: rtl/bypass_cam_buff.sv
// bypass_cam_buff: fully associative write-back bypass buffer.
// Recent write-back results sit in a small CAM and are forwarded to
// NUM_SRC operand ports ahead of the register file. Each source owns a
// slice FSM that decides whether a CAM hit is single-use (scalar access)
// or must persist for the whole slice.
//
// Port protocol: every request is valid-only and there is no ready. A
// source is looked up combinationally in the cycle that I_Src_Valid[k] is
// high. A write-back is accepted at the clock edge of any cycle with
// I_WB_Valid high, and I_Stall does not block it. The buffer never
// back-pressures: when it is full, the victim entry is overwritten.
module bypass_cam_buff #(
    parameter int NUM_SRC    = 3,
    parameter int BUFF_SIZE  = 8,
    parameter int WIDTH_IDX  = 8,
    parameter int WIDTH_DATA = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             I_Stall,
    input  logic                             I_WB_Valid,
    input  logic [WIDTH_IDX-1:0]             I_WB_Index,
    input  logic [WIDTH_DATA-1:0]            I_WB_Data,
    input  logic [WIDTH_IDX-1:0]             I_Slice_Len,
    input  logic [NUM_SRC-1:0]               I_Src_Valid,
    input  logic [NUM_SRC*WIDTH_IDX-1:0]     I_Src_Idx,
    input  logic [NUM_SRC*WIDTH_DATA-1:0]    I_Src_Data,
    output logic [NUM_SRC*WIDTH_DATA-1:0]    O_Src_Data,
    output logic [NUM_SRC-1:0]               O_Hit,
    output logic                             O_Full,
    output logic                             O_Empty,
    output logic [$clog2(BUFF_SIZE+1)-1:0]   O_Num,
    output logic [NUM_SRC-1:0]               O_Slice_Run
);

    localparam int NUM_W = $clog2(BUFF_SIZE + 1);
    localparam int PTR_W = $clog2(BUFF_SIZE);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } slice_state_t;

    // CAM storage
    logic [BUFF_SIZE-1:0]  ent_valid;
    logic [WIDTH_IDX-1:0]  ent_idx  [BUFF_SIZE];
    logic [WIDTH_DATA-1:0] ent_data [BUFF_SIZE];
    logic [PTR_W-1:0]      victim_ptr;

    // Slice FSMs
    slice_state_t          slice_state     [NUM_SRC];
    slice_state_t          slice_state_nxt [NUM_SRC];
    logic [WIDTH_IDX-1:0]  slice_end       [NUM_SRC];
    logic [WIDTH_IDX-1:0]  slice_end_nxt   [NUM_SRC];

    // Write path
    logic [BUFF_SIZE-1:0]  wb_match;
    logic                  wb_hit;
    logic                  buf_full;
    logic                  evict;
    logic [PTR_W-1:0]      wb_sel;
    logic [PTR_W-1:0]      free_sel;
    logic [PTR_W-1:0]      wr_sel;

    // Lookup path
    logic [WIDTH_IDX-1:0]  src_idx   [NUM_SRC];
    logic [BUFF_SIZE-1:0]  src_match [NUM_SRC];
    logic [WIDTH_DATA-1:0] cam_data  [NUM_SRC];
    logic [NUM_SRC-1:0]    wb_fwd;
    logic [NUM_SRC-1:0]    cam_hit;
    logic [NUM_SRC-1:0]    enter_run;
    logic [BUFF_SIZE-1:0]  consume;

    // Split the packed source index bus into one index per source
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_idx[k] = I_Src_Idx[k*WIDTH_IDX +: WIDTH_IDX];
        end
    end

    // Pick the write target: in-place match, else lowest free, else victim
    always_comb begin
        wb_match = '0;
        wb_sel   = '0;
        free_sel = '0;
        for (int e = 0; e < BUFF_SIZE; e++) begin
            wb_match[e] = ent_valid[e] && (ent_idx[e] == I_WB_Index);
            if (wb_match[e]) begin
                wb_sel = PTR_W'(e);
            end
        end
        for (int e = BUFF_SIZE - 1; e >= 0; e--) begin
            if (!ent_valid[e]) begin
                free_sel = PTR_W'(e);
            end
        end
        wb_hit   = |wb_match;
        buf_full = &ent_valid;
        evict    = I_WB_Valid && !wb_hit && buf_full;
        if (wb_hit) begin
            wr_sel = wb_sel;
        end else if (!buf_full) begin
            wr_sel = free_sel;
        end else begin
            wr_sel = victim_ptr;
        end
    end

    // Per-source forwarding: write-back beats CAM beats register file
    always_comb begin
        O_Src_Data = '0;
        O_Hit      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            wb_fwd[k]   = I_Src_Valid[k] && I_WB_Valid && (I_WB_Index == src_idx[k]);
            cam_data[k] = '0;
            for (int e = 0; e < BUFF_SIZE; e++) begin
                src_match[k][e] = I_Src_Valid[k] && ent_valid[e] && (ent_idx[e] == src_idx[k]);
                if (src_match[k][e]) begin
                    cam_data[k] = cam_data[k] | ent_data[e];
                end
            end
            cam_hit[k] = |src_match[k];
            if (wb_fwd[k]) begin
                O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = I_WB_Data;
            end else if (cam_hit[k]) begin
                O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = cam_data[k];
            end else if (I_Src_Valid[k]) begin
                O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = I_Src_Data[k*WIDTH_DATA +: WIDTH_DATA];
            end
            O_Hit[k] = wb_fwd[k] | cam_hit[k];
        end
    end

    // Slice FSM next state and single-use consumption of CAM hits
    always_comb begin
        consume = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            slice_state_nxt[k] = slice_state[k];
            slice_end_nxt[k]   = slice_end[k];
            enter_run[k]       = 1'b0;
            if (!I_Stall) begin
                case (slice_state[k])
                    S_IDLE: begin
                        if (I_Src_Valid[k] && (I_Slice_Len != '0)) begin
                            enter_run[k]       = 1'b1;
                            slice_state_nxt[k] = S_RUN;
                            // Wraps modulo 2^WIDTH_IDX by design
                            slice_end_nxt[k]   = src_idx[k] + I_Slice_Len;
                        end
                    end
                    S_RUN: begin
                        if (I_Src_Valid[k] && (src_idx[k] == slice_end[k])) begin
                            slice_state_nxt[k] = S_IDLE;
                        end
                    end
                    default: slice_state_nxt[k] = S_IDLE;
                endcase
            end
            // Only a plain scalar access from an idle source uses an entry up
            if (!I_Stall && (slice_state[k] == S_IDLE) && !enter_run[k] && !wb_fwd[k]) begin
                consume = consume | src_match[k];
            end
        end
    end

    // CAM update: a write to an entry overrides its consumption
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid  <= '0;
            victim_ptr <= '0;
            for (int e = 0; e < BUFF_SIZE; e++) begin
                ent_idx[e]  <= '0;
                ent_data[e] <= '0;
            end
        end else begin
            for (int e = 0; e < BUFF_SIZE; e++) begin
                if (I_WB_Valid && (wr_sel == PTR_W'(e))) begin
                    ent_valid[e] <= 1'b1;
                    ent_idx[e]   <= I_WB_Index;
                    ent_data[e]  <= I_WB_Data;
                end else if (consume[e]) begin
                    ent_valid[e] <= 1'b0;
                end
            end
            if (evict) begin
                victim_ptr <= (victim_ptr == PTR_W'(BUFF_SIZE - 1)) ? '0 : victim_ptr + PTR_W'(1);
            end
        end
    end

    // Slice FSM state and end-index registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                slice_state[k] <= S_IDLE;
                slice_end[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                slice_state[k] <= slice_state_nxt[k];
                slice_end[k]   <= slice_end_nxt[k];
            end
        end
    end

    // Occupancy status derived from the valid bits
    always_comb begin
        O_Num = '0;
        for (int e = 0; e < BUFF_SIZE; e++) begin
            O_Num = O_Num + NUM_W'(ent_valid[e]);
        end
        O_Full  = (O_Num == NUM_W'(BUFF_SIZE));
        O_Empty = (O_Num == '0);
    end

    // Debug view of each slice FSM (1 = RUN)
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            O_Slice_Run[k] = (slice_state[k] == S_RUN);
        end
    end

endmodule

// File: tb/tb_bypass_cam_buff.sv
// tb_bypass_cam_buff: directed vector table for bypass_cam_buff plus
// hand-written reset sequences. Each vector is one clock cycle.
module tb_bypass_cam_buff;

    localparam logic [31:0] M0 = 32'hDEAD_0000;
    localparam logic [31:0] M1 = 32'hDEAD_0001;
    localparam logic [31:0] M2 = 32'hDEAD_0002;

    logic        clock;
    logic        reset;
    logic        I_Stall;
    logic        I_WB_Valid;
    logic [7:0]  I_WB_Index;
    logic [31:0] I_WB_Data;
    logic [7:0]  I_Slice_Len;
    logic [2:0]  I_Src_Valid;
    logic [23:0] I_Src_Idx;
    logic [95:0] I_Src_Data;
    logic [95:0] O_Src_Data;
    logic [2:0]  O_Hit;
    logic        O_Full;
    logic        O_Empty;
    logic [3:0]  O_Num;
    logic [2:0]  O_Slice_Run;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        st;
        logic        wv;
        logic [7:0]  wi;
        logic [31:0] wd;
        logic [7:0]  sl;
        logic [2:0]  sv;
        logic [7:0]  i0, i1, i2;
        logic [31:0] x0, x1, x2;
        logic [2:0]  hit;
        int          num;
        logic [2:0]  run;
    } vec_t;

    vec_t vecs[$];

    bypass_cam_buff #(
        .NUM_SRC(3), .BUFF_SIZE(8), .WIDTH_IDX(8), .WIDTH_DATA(32)
    ) dut (
        .clock(clock), .reset(reset), .I_Stall(I_Stall),
        .I_WB_Valid(I_WB_Valid), .I_WB_Index(I_WB_Index), .I_WB_Data(I_WB_Data),
        .I_Slice_Len(I_Slice_Len), .I_Src_Valid(I_Src_Valid), .I_Src_Idx(I_Src_Idx),
        .I_Src_Data(I_Src_Data), .O_Src_Data(O_Src_Data), .O_Hit(O_Hit),
        .O_Full(O_Full), .O_Empty(O_Empty), .O_Num(O_Num), .O_Slice_Run(O_Slice_Run)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic st, input logic wv, input logic [7:0] wi,
                                input logic [31:0] wd, input logic [7:0] sl, input logic [2:0] sv,
                                input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2,
                                input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [2:0] hit, input int num, input logic [2:0] run);
        vec_t v;
        v.st = st; v.wv = wv; v.wi = wi; v.wd = wd; v.sl = sl; v.sv = sv;
        v.i0 = i0; v.i1 = i1; v.i2 = i2; v.x0 = x0; v.x1 = x1; v.x2 = x2;
        v.hit = hit; v.num = num; v.run = run;
        return v;
    endfunction

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", what, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        I_Stall     = v.st;
        I_WB_Valid  = v.wv;
        I_WB_Index  = v.wi;
        I_WB_Data   = v.wd;
        I_Slice_Len = v.sl;
        I_Src_Valid = v.sv;
        I_Src_Idx   = {v.i2, v.i1, v.i0};
    endtask

    task automatic check_vec(input int n, input vec_t v);
        chk($sformatf("v%0d.data0", n), O_Src_Data[31:0],  v.x0);
        chk($sformatf("v%0d.data1", n), O_Src_Data[63:32], v.x1);
        chk($sformatf("v%0d.data2", n), O_Src_Data[95:64], v.x2);
        chk($sformatf("v%0d.hit", n),   {29'd0, O_Hit},    {29'd0, v.hit});
        chk($sformatf("v%0d.num", n),   {28'd0, O_Num},    32'(v.num));
        chk($sformatf("v%0d.full", n),  {31'd0, O_Full},   {31'd0, (v.num == 8)});
        chk($sformatf("v%0d.empty", n), {31'd0, O_Empty},  {31'd0, (v.num == 0)});
        chk($sformatf("v%0d.run", n),   {29'd0, O_Slice_Run}, {29'd0, v.run});
    endtask

    task automatic idle_inputs();
        I_Stall = 1'b0; I_WB_Valid = 1'b0; I_WB_Index = '0; I_WB_Data = '0;
        I_Slice_Len = '0; I_Src_Valid = '0; I_Src_Idx = '0;
    endtask

    initial begin
        // Reset block
        reset = 1'b1;
        idle_inputs();
        I_Src_Data = {M2, M1, M0};
        I_Src_Valid = 3'b001;
        #1;
        chk("rst.num",   {28'd0, O_Num},       32'd0);
        chk("rst.empty", {31'd0, O_Empty},     32'd1);
        chk("rst.full",  {31'd0, O_Full},      32'd0);
        chk("rst.hit",   {29'd0, O_Hit},       32'd0);
        chk("rst.run",   {29'd0, O_Slice_Run}, 32'd0);
        chk("rst.data0", O_Src_Data[31:0],     M0);
        chk("rst.data1", O_Src_Data[63:32],    32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();

        // Scalar consume
        vecs.push_back(mk(0,1,5,'hA5,0,3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b001,5,0,0, 'hA5,0,0, 3'b001,1,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b001,5,0,0, M0,0,0, 3'b000,0,3'b000));
        // Same-cycle forwarding, then write-path hit does not consume
        vecs.push_back(mk(0,1,3,'h33,0,3'b110,0,3,3, 0,'h33,'h33, 3'b110,0,3'b000));
        vecs.push_back(mk(0,1,3,'h34,0,3'b001,3,0,0, 'h34,0,0, 3'b001,1,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b001,3,0,0, 'h34,0,0, 3'b001,1,3'b000));
        // In-place update
        vecs.push_back(mk(0,1,4,'h11,0,3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000));
        vecs.push_back(mk(0,1,4,'h22,0,3'b000,0,0,0, 0,0,0, 3'b000,1,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b000,0,0,0, 0,0,0, 3'b000,1,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b010,0,4,0, 0,'h22,0, 3'b010,1,3'b000));
        // Fill idx 0..7
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0,1,8'(i),32'h100 + 32'(i),0,3'b000,0,0,0, 0,0,0, 3'b000,i,3'b000));
        end
        // Full: evict entry 0 while entries 0 and 5 are consumed
        vecs.push_back(mk(0,1,9,'h109,0,3'b011,0,5,0, 'h100,'h105,0, 3'b011,8,3'b000));
        vecs.push_back(mk(1,0,0,0,0,3'b011,0,9,0, M0,'h109,0, 3'b010,7,3'b000));
        vecs.push_back(mk(0,1,'h20,'h120,0,3'b000,0,0,0, 0,0,0, 3'b000,7,3'b000));
        vecs.push_back(mk(0,1,10,'h10A,0,3'b000,0,0,0, 0,0,0, 3'b000,8,3'b000));
        // Stall: hits kept, write still stored (evicts entry 2)
        vecs.push_back(mk(1,1,'h30,'h130,0,3'b111,1,10,'h20, M0,'h10A,'h120, 3'b110,8,3'b000));
        vecs.push_back(mk(1,0,0,0,5,3'b101,'h30,0,2, 'h130,0,M2, 3'b001,8,3'b000));
        vecs.push_back(mk(0,1,2,'h202,0,3'b000,0,0,0, 0,0,0, 3'b000,8,3'b000));
        // Slice 250 + 8 -> End = 2
        vecs.push_back(mk(0,0,0,0,8,3'b001,250,0,0, M0,0,0, 3'b000,8,3'b000));
        vecs.push_back(mk(0,0,0,0,8,3'b001,7,0,0, 'h107,0,0, 3'b001,8,3'b001));
        vecs.push_back(mk(0,0,0,0,8,3'b000,0,0,0, 0,0,0, 3'b000,8,3'b001));
        vecs.push_back(mk(0,0,0,0,8,3'b001,7,0,0, 'h107,0,0, 3'b001,8,3'b001));
        vecs.push_back(mk(0,0,0,0,8,3'b001,2,0,0, 'h202,0,0, 3'b001,8,3'b001));
        vecs.push_back(mk(0,0,0,0,0,3'b001,2,0,0, 'h202,0,0, 3'b001,8,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b001,2,0,0, M0,0,0, 3'b000,7,3'b000));
        // Hit on RUN-entry cycle keeps the entry
        vecs.push_back(mk(0,0,0,0,2,3'b001,6,0,0, 'h106,0,0, 3'b001,7,3'b000));
        vecs.push_back(mk(0,0,0,0,2,3'b001,8,0,0, M0,0,0, 3'b000,7,3'b001));
        vecs.push_back(mk(0,0,0,0,0,3'b001,6,0,0, 'h106,0,0, 3'b001,7,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b000,0,0,0, 0,0,0, 3'b000,6,3'b000));
        // Two sources hit the same entry: one invalidation
        vecs.push_back(mk(0,0,0,0,0,3'b011,7,7,0, 'h107,'h107,0, 3'b011,6,3'b000));
        vecs.push_back(mk(0,0,0,0,0,3'b000,0,0,0, 0,0,0, 3'b000,5,3'b000));

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n]);
            #2;
            check_vec(n, vecs[n]);
            @(negedge clock);
        end

        // Reset mid-slice
        idle_inputs();
        I_Src_Valid = 3'b010;
        I_Src_Idx   = {8'd0, 8'h40, 8'd0};
        I_Slice_Len = 8'd4;
        @(negedge clock);
        idle_inputs();
        #1;
        chk("mid.run_before", {29'd0, O_Slice_Run}, 32'd2);
        chk("mid.num_before", {28'd0, O_Num},       32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.num",   {28'd0, O_Num},       32'd0);
        chk("mid.empty", {31'd0, O_Empty},     32'd1);
        chk("mid.full",  {31'd0, O_Full},      32'd0);
        chk("mid.run",   {29'd0, O_Slice_Run}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        I_Src_Valid = 3'b001;
        I_Src_Idx   = {8'd0, 8'd0, 8'd9};
        #2;
        chk("post.data0", O_Src_Data[31:0], M0);
        chk("post.hit",   {29'd0, O_Hit},   32'd0);
        @(negedge clock);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
